// File: rtl/btb_sched_pkg.sv
// Shared definitions for the BTB port scheduler: default sizes, FSM
// state encoding and the layout of one queued BTB update.
package btb_sched_pkg;

  localparam int BTB_SIZE_DEF   = 64;
  localparam int UPD_QDEPTH_DEF = 4;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SWEEP = 1'b1
  } btb_state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] target;
    logic        taken;
  } btb_upd_t;

endpackage

// File: rtl/btb_upd_fifo.sv
// Update queue for resolved branches. Entries leave in arrival order.
// A push and a pop in the same cycle leave the occupancy unchanged, and
// clear drops every queued entry (used when a full BTB flush starts).
module btb_upd_fifo
  import btb_sched_pkg::*;
#(
  parameter int DEPTH = UPD_QDEPTH_DEF
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clear,
  input  logic                     push,
  input  btb_upd_t                 push_data,
  input  logic                     pop,
  output btb_upd_t                 head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  btb_upd_t        mem_q [DEPTH];
  btb_upd_t        mem_d [DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            push_ok;
  logic            pop_ok;

  assign full  = (count_q == DEPTH_C);
  assign empty = (count_q == {CW{1'b0}});
  assign count = count_q;
  assign head  = mem_q[rd_ptr_q];

  // Next-state for storage, pointers and occupancy; clear wins over push/pop.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    push_ok  = push && !full;
    pop_ok   = pop && !empty;
    if (clear) begin
      wr_ptr_d = {PW{1'b0}};
      rd_ptr_d = {PW{1'b0}};
      count_d  = {CW{1'b0}};
    end else begin
      if (push_ok) begin
        mem_d[wr_ptr_q] = push_data;
        wr_ptr_d        = wr_ptr_q + PW'(1);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (pop_ok) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({push_ok, pop_ok})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Pointer and occupancy registers; the queue restarts empty on reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= {PW{1'b0}};
      rd_ptr_q <= {PW{1'b0}};
      count_q  <= {CW{1'b0}};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage; contents are meaningless until written, so no reset.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/btb_sched.sv
// Arbitrates the single BTB port between fetch lookups, queued branch
// updates from execute, and a full-table invalidation sweep.
// Fetch normally owns the port; queued updates use it when fetch is idle
// or when the queue is full. A sweep writes every entry back to zero, one
// per cycle, and stalls fetch while it runs.
module btb_sched
  import btb_sched_pkg::*;
#(
  parameter int SIZE   = BTB_SIZE_DEF,
  parameter int QDEPTH = UPD_QDEPTH_DEF
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      fetch_valid,
  input  logic [31:0]               fetch_pc,
  input  logic                      res_valid,
  input  logic [31:0]               res_pc,
  input  logic [31:0]               res_target,
  input  logic                      res_taken,
  output logic                      res_ready,
  input  logic                      flush_req,
  output logic                      flush_busy,
  output logic                      fetch_stall,
  output logic                      btb_en,
  output logic [31:0]               btb_pc,
  output logic [31:0]               btb_target,
  output logic                      btb_taken,
  output logic [$clog2(QDEPTH):0]   q_count
);

  localparam int IW = $clog2(SIZE);
  localparam logic [IW-1:0] LAST_IDX = IW'(SIZE - 1);

  btb_state_e    state_q, state_d;
  logic [IW-1:0] sweep_idx_q, sweep_idx_d;

  logic          q_push;
  logic          q_pop;
  logic          q_clear;
  btb_upd_t      q_in;
  btb_upd_t      q_head;
  logic          q_full;
  logic          q_empty;

  assign q_in = '{pc: res_pc, target: res_target, taken: res_taken};

  btb_upd_fifo #(
    .DEPTH (QDEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .clear     (q_clear),
    .push      (q_push),
    .push_data (q_in),
    .pop       (q_pop),
    .head      (q_head),
    .full      (q_full),
    .empty     (q_empty),
    .count     (q_count)
  );

  // Port arbitration, queue control and FSM next-state. Port outputs never
  // depend on res_*: those only feed the queue push.
  always_comb begin
    state_d     = state_q;
    sweep_idx_d = sweep_idx_q;
    btb_en      = 1'b0;
    btb_pc      = fetch_pc;
    btb_target  = 32'h0000_0000;
    btb_taken   = 1'b0;
    fetch_stall = 1'b0;
    flush_busy  = 1'b0;
    res_ready   = 1'b0;
    q_push      = 1'b0;
    q_pop       = 1'b0;
    q_clear     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        res_ready = !q_full;
        q_push    = res_valid && !q_full;
        if (!q_empty && (!fetch_valid || q_full)) begin
          btb_en      = 1'b1;
          btb_pc      = q_head.pc;
          btb_target  = q_head.target;
          btb_taken   = q_head.taken;
          fetch_stall = fetch_valid;
          q_pop       = 1'b1;
        end else begin
          btb_en      = 1'b0;
          btb_pc      = fetch_pc;
          fetch_stall = 1'b0;
          q_pop       = 1'b0;
        end
        // A resolution accepted this cycle is dropped by the clear too.
        if (flush_req) begin
          state_d     = ST_SWEEP;
          sweep_idx_d = {IW{1'b0}};
          q_clear     = 1'b1;
        end else begin
          state_d     = ST_IDLE;
          q_clear     = 1'b0;
        end
      end
      ST_SWEEP: begin
        btb_en      = 1'b1;
        btb_pc      = {{(30 - IW){1'b0}}, sweep_idx_q, 2'b00};
        btb_target  = 32'h0000_0000;
        btb_taken   = 1'b0;
        fetch_stall = 1'b1;
        flush_busy  = 1'b1;
        res_ready   = 1'b0;
        if (sweep_idx_q == LAST_IDX) begin
          state_d     = ST_IDLE;
          sweep_idx_d = {IW{1'b0}};
        end else begin
          state_d     = ST_SWEEP;
          sweep_idx_d = sweep_idx_q + IW'(1);
        end
      end
      default: begin
        state_d     = ST_IDLE;
        sweep_idx_d = {IW{1'b0}};
      end
    endcase
  end

  // FSM state and sweep index; reset aborts any sweep in progress.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      sweep_idx_q <= {IW{1'b0}};
    end else begin
      state_q     <= state_d;
      sweep_idx_q <= sweep_idx_d;
    end
  end

endmodule

// File: tb/tb_btb_sched.sv
// Self-checking bench for btb_sched: directed scenarios followed by random
// traffic, all compared against a queue-based behavioural model.
module tb_btb_sched;

  localparam int SIZE = 64;
  localparam int QD   = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        fetch_valid;
  logic [31:0] fetch_pc;
  logic        res_valid;
  logic [31:0] res_pc;
  logic [31:0] res_target;
  logic        res_taken;
  logic        res_ready;
  logic        flush_req;
  logic        flush_busy;
  logic        fetch_stall;
  logic        btb_en;
  logic [31:0] btb_pc;
  logic [31:0] btb_target;
  logic        btb_taken;
  logic [2:0]  q_count;

  btb_sched #(.SIZE(SIZE), .QDEPTH(QD)) dut (
    .clk         (clk),
    .reset       (reset),
    .fetch_valid (fetch_valid),
    .fetch_pc    (fetch_pc),
    .res_valid   (res_valid),
    .res_pc      (res_pc),
    .res_target  (res_target),
    .res_taken   (res_taken),
    .res_ready   (res_ready),
    .flush_req   (flush_req),
    .flush_busy  (flush_busy),
    .fetch_stall (fetch_stall),
    .btb_en      (btb_en),
    .btb_pc      (btb_pc),
    .btb_target  (btb_target),
    .btb_taken   (btb_taken),
    .q_count     (q_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] tgt;
    logic        tk;
  } ent_t;

  ent_t mq[$];
  bit   m_sweep;
  int   m_idx;
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // One clock cycle: drive at negedge, check outputs, then advance the model
  // to what the following rising edge should produce.
  task automatic step(input logic fv, input logic [31:0] fpc, input logic rv,
                      input logic [31:0] rpc, input logic [31:0] rtg,
                      input logic rtk, input logic fl);
    bit   upd;
    bit   rdy;
    ent_t e;
    @(negedge clk);
    fetch_valid = fv; fetch_pc = fpc; res_valid = rv; res_pc = rpc;
    res_target = rtg; res_taken = rtk; flush_req = fl;
    #1;
    if (m_sweep) begin
      check_val("sweep_en",    32'(btb_en), 32'd1);
      check_val("sweep_pc",    btb_pc, 32'(m_idx * 4));
      check_val("sweep_tgt",   btb_target, 32'd0);
      check_val("sweep_tk",    32'(btb_taken), 32'd0);
      check_val("sweep_busy",  32'(flush_busy), 32'd1);
      check_val("sweep_stall", 32'(fetch_stall), 32'd1);
      check_val("sweep_ready", 32'(res_ready), 32'd0);
      check_val("sweep_count", 32'(q_count), 32'd0);
      m_idx++;
      if (m_idx == SIZE) begin
        m_sweep = 1'b0;
        m_idx   = 0;
      end
    end else begin
      rdy = (mq.size() < QD);
      upd = (mq.size() > 0) && (!fv || mq.size() == QD);
      check_val("en",    32'(btb_en), 32'(upd));
      check_val("busy",  32'(flush_busy), 32'd0);
      check_val("stall", 32'(fetch_stall), 32'(upd && fv));
      check_val("ready", 32'(res_ready), 32'(rdy));
      check_val("count", 32'(q_count), 32'(mq.size()));
      if (upd) begin
        check_val("upd_pc",  btb_pc, mq[0].pc);
        check_val("upd_tgt", btb_target, mq[0].tgt);
        check_val("upd_tk",  32'(btb_taken), 32'(mq[0].tk));
        void'(mq.pop_front());
      end else begin
        check_val("lookup_pc", btb_pc, fpc);
      end
      if (rv && rdy) begin
        e.pc = rpc; e.tgt = rtg; e.tk = rtk;
        mq.push_back(e);
      end
      if (fl) begin
        mq.delete();
        m_sweep = 1'b1;
        m_idx   = 0;
      end
    end
  endtask

  // Asynchronous reset pulse starting at a negedge; effect checked before
  // any clock edge arrives.
  task automatic pulse_reset();
    logic [31:0] fpc;
    fpc = $urandom;
    @(negedge clk);
    fetch_valid = 1'b1; fetch_pc = fpc; res_valid = 1'b0; flush_req = 1'b0;
    reset = 1'b1;
    #1;
    check_val("rst_en",    32'(btb_en), 32'd0);
    check_val("rst_busy",  32'(flush_busy), 32'd0);
    check_val("rst_stall", 32'(fetch_stall), 32'd0);
    check_val("rst_ready", 32'(res_ready), 32'd1);
    check_val("rst_count", 32'(q_count), 32'd0);
    check_val("rst_pc",    btb_pc, fpc);
    mq.delete();
    m_sweep = 1'b0;
    m_idx   = 0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; fetch_valid = 1'b0; fetch_pc = 32'd0; res_valid = 1'b0;
    res_pc = 32'd0; res_target = 32'd0; res_taken = 1'b0; flush_req = 1'b0;
    mq.delete(); m_sweep = 1'b0; m_idx = 0;
    pulse_reset();

    // Idle lookup right after reset.
    step(1'b1, 32'h0000_1234, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);

    // Single resolution written the following cycle with fetch idle.
    step(1'b0, 32'h0, 1'b1, 32'h0000_0040, 32'h0000_0100, 1'b1, 1'b0);
    step(1'b0, 32'h0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
    step(1'b0, 32'h0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);

    // Fetch busy: four pushes fill the queue, then a forced update stalls fetch.
    for (int i = 0; i < 4; i++)
      step(1'b1, $urandom, 1'b1, 32'h100 + 32'(i * 4), $urandom, 1'(i), 1'b0);
    step(1'b1, 32'h2000, 1'b1, 32'h500, 32'h600, 1'b1, 1'b0);
    step(1'b1, 32'h2004, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++)
      step(1'b0, 32'd0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);

    // Flush with two queued entries and a resolution offered in the flush cycle.
    step(1'b1, 32'h40, 1'b1, 32'h800, 32'h900, 1'b1, 1'b0);
    step(1'b1, 32'h44, 1'b1, 32'h804, 32'h904, 1'b0, 1'b0);
    step(1'b1, 32'h48, 1'b1, 32'h808, 32'h908, 1'b1, 1'b1);
    for (int i = 0; i < SIZE; i++)
      step(1'b1, $urandom, 1'b1, $urandom, $urandom, 1'b1, (i == 5) ? 1'b1 : 1'b0);
    step(1'b1, 32'h4c, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);

    // Reset during sweep cycle 10, then an unstalled lookup.
    step(1'b0, 32'h0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b1);
    for (int i = 0; i < 10; i++)
      step(1'b1, $urandom, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
    pulse_reset();
    step(1'b1, 32'h0000_7770, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);

    // Simultaneous enqueue and dequeue at occupancy two.
    step(1'b1, 32'h0, 1'b1, 32'hA00, 32'hB00, 1'b1, 1'b0);
    step(1'b1, 32'h0, 1'b1, 32'hA04, 32'hB04, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++)
      step(1'b0, 32'h0, 1'b1, 32'hA10 + 32'(i * 4), 32'hB10 + 32'(i * 4), 1'(i), 1'b0);
    for (int i = 0; i < 4; i++)
      step(1'b0, 32'h0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);

    // Random traffic with occasional flushes and resets.
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 599) == 0) begin
        pulse_reset();
      end else begin
        step(($urandom_range(0, 3) != 0), $urandom, 1'($urandom_range(0, 1)),
             $urandom, $urandom, 1'($urandom_range(0, 1)),
             ($urandom_range(0, 199) == 0));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
